// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2), decode/execute (T3-T6), HALT.
// Define SEQ_MULDIV_EN to enable MUL/DIV (opcodes 5'h0A/5'h0B); otherwise they trap as illegal.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        MDRread,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        HIin,
    output logic        LOin,
    output logic        Cout,
    output logic [4:0]  ALUselect,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_cnt
);

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

    state_t     state, state_nxt;
    logic [4:0] op;
    logic       is_r, is_addi, is_md, is_nop, is_halt, is_ill;
    logic       done;
    logic       unused_ir_bits;

    assign op             = ir[31:27];
    assign unused_ir_bits = ^ir[26:0];
    assign is_r           = (op <= 5'h08);
    assign is_addi        = (op == 5'h09);
    assign is_nop         = (op == 5'h0C);
    assign is_halt        = (op == 5'h0D);
`ifdef SEQ_MULDIV_EN
    assign is_md          = (op == 5'h0A) || (op == 5'h0B);
`else
    assign is_md          = 1'b0;
`endif
    assign is_ill         = !(is_r || is_addi || is_md || is_nop || is_halt);
    assign halted         = (state == HALT);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            instr_cnt <= 16'h0000;
            illegal   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (done)
                instr_cnt <= instr_cnt + 16'h0001;
            // illegal is sticky until reset, latched on the way into HALT
            if (state == T3 && is_ill)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        PCout     = 1'b0;  MARin    = 1'b0;  IncPC   = 1'b0;
        MDRread   = 1'b0;  MDRin    = 1'b0;  MDRout  = 1'b0;  IRin = 1'b0;
        Gra       = 1'b0;  Grb      = 1'b0;  Grc     = 1'b0;
        Rin       = 1'b0;  Rout     = 1'b0;  Yin     = 1'b0;
        Zlowin    = 1'b0;  Zhighin  = 1'b0;  ZLowout = 1'b0;  ZHighout = 1'b0;
        HIin      = 1'b0;  LOin     = 1'b0;  Cout    = 1'b0;
        ALUselect = 5'h00;

        case (state)
            IDLE: if (run) state_nxt = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                MDRread = 1'b1; MDRin = 1'b1;
                if (mem_rdy) state_nxt = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                if (is_md) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    state_nxt = T4;
                end else if (is_r || is_addi) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    state_nxt = T4;
                end else if (is_nop) begin
                    done = 1'b1;
                end else begin
                    state_nxt = HALT;
                end
            end
            T4: begin
                Zlowin = 1'b1; Zhighin = 1'b1;
                if (is_addi) begin
                    Cout = 1'b1;
                end else begin
                    Rout      = 1'b1;
                    ALUselect = op;
                    if (is_md) Grb = 1'b1;
                    else       Grc = 1'b1;
                end
                state_nxt = T5;
            end
            T5: begin
                ZLowout = 1'b1;
                if (is_md) begin
                    LOin = 1'b1;
                    state_nxt = T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    done = 1'b1;
                end
            end
            T6: begin
                ZHighout = 1'b1; HIin = 1'b1;
                done = 1'b1;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase

        // run is only consulted at instruction boundaries
        if (done)
            state_nxt = run ? T0 : IDLE;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboarded directed bench for control_sequencer: per-cycle expected control
// words are queued per instruction and checked one per clock.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr, run, mem_rdy;
    logic [31:0] ir;
    logic        PCout, MARin, IncPC, MDRread, MDRin, MDRout, IRin;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic        Yin, Zlowin, Zhighin, ZLowout, ZHighout, HIin, LOin, Cout;
    logic [4:0]  ALUselect;
    logic        halted, illegal;
    logic [15:0] instr_cnt;

    control_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_rdy(mem_rdy),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .MDRread(MDRread),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .ZLowout(ZLowout),
        .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin), .Cout(Cout),
        .ALUselect(ALUselect), .halted(halted), .illegal(illegal),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

`ifdef SEQ_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [26:0] PCO = 27'h1 << 26, MAR = 27'h1 << 25, INC = 27'h1 << 24;
    localparam logic [26:0] MRD = 27'h1 << 23, MDI = 27'h1 << 22, MDO = 27'h1 << 21;
    localparam logic [26:0] IRI = 27'h1 << 20, GRA = 27'h1 << 19, GRB = 27'h1 << 18;
    localparam logic [26:0] GRC = 27'h1 << 17, RIN = 27'h1 << 16, ROUT = 27'h1 << 15;
    localparam logic [26:0] YIN = 27'h1 << 14, ZLI = 27'h1 << 13, ZHI = 27'h1 << 12;
    localparam logic [26:0] ZLO = 27'h1 << 11, ZHO = 27'h1 << 10, HII = 27'h1 << 9;
    localparam logic [26:0] LOI = 27'h1 << 8,  COUT = 27'h1 << 7;
    localparam logic [26:0] HLT = 27'h1 << 1,  ILL = 27'h1 << 0;

    typedef struct packed {
        logic [26:0] ctrl;
        logic [15:0] cnt;
        logic        rdy;
    } ent_t;

    ent_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt;
    logic [26:0] obs;

    assign obs = {PCout, MARin, IncPC, MDRread, MDRin, MDRout, IRin,
                  Gra, Grb, Grc, Rin, Rout, Yin, Zlowin, Zhighin,
                  ZLowout, ZHighout, HIin, LOin, Cout, ALUselect, halted, illegal};

    function automatic logic [26:0] alu(input logic [4:0] o);
        return {20'b0, o, 2'b0};
    endfunction

    task automatic chk(input string tag, input logic [26:0] ec, input logic [15:0] ecnt);
        total++;
        assert (obs === ec) else begin
            bad++;
            $error("FAIL %s ctrl got=%h want=%h", tag, obs, ec);
        end
        total++;
        assert (instr_cnt === ecnt) else begin
            bad++;
            $error("FAIL %s instr_cnt got=%h want=%h", tag, instr_cnt, ecnt);
        end
    endtask

    task automatic push(input logic [26:0] c, input logic r);
        ent_t e;
        e.ctrl = c;
        e.cnt  = exp_cnt;
        e.rdy  = r;
        sb.push_back(e);
    endtask

    // Reference sequence for one instruction, starting at T0.
    task automatic push_instr(input logic [4:0] o, input int waits);
        bit md;
        md = MD_EN && (o == 5'h0A || o == 5'h0B);
        push(PCO | MAR | INC, 1'b0);
        for (int i = 0; i < waits; i++) push(MRD | MDI, 1'b0);
        push(MRD | MDI, 1'b1);
        push(MDO | IRI, 1'b0);
        if (md) begin
            push(GRA | ROUT | YIN, 1'b0);
            push(GRB | ROUT | ZLI | ZHI | alu(o), 1'b0);
            push(ZLO | LOI, 1'b0);
            push(ZHO | HII, 1'b0);
            exp_cnt++;
        end else if (o <= 5'h08) begin
            push(GRB | ROUT | YIN, 1'b0);
            push(GRC | ROUT | ZLI | ZHI | alu(o), 1'b0);
            push(ZLO | GRA | RIN, 1'b0);
            exp_cnt++;
        end else if (o == 5'h09) begin
            push(GRB | ROUT | YIN, 1'b0);
            push(COUT | ZLI | ZHI, 1'b0);
            push(ZLO | GRA | RIN, 1'b0);
            exp_cnt++;
        end else if (o == 5'h0C) begin
            push(27'h0, 1'b0);
            exp_cnt++;
        end else if (o == 5'h0D) begin
            push(27'h0, 1'b0);
            push(HLT, 1'b0);
        end else begin
            push(27'h0, 1'b0);
            push(HLT | ILL, 1'b0);
        end
    endtask

    // Pop and check one entry per clock; ir/run are changed once T0 is observed.
    task automatic drain(input string tag, input logic [4:0] o, input logic run_mid, input int n);
        int   k = 0;
        ent_t e;
        while (sb.size() > 0 && (n < 0 || k < n)) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            chk($sformatf("%s[%0d]", tag, k), e.ctrl, e.cnt);
            mem_rdy = e.rdy;
            if (k == 0) begin
                ir  = {o, 27'($urandom)};
                run = run_mid;
            end
            k++;
        end
    endtask

    task automatic pulse_clr(input string tag);
        run = 1'b0;
        @(posedge clk); #3;
        clr = 1'b0;
        #1;
        exp_cnt = 16'h0000;
        chk({tag, "_async"}, 27'h0, exp_cnt);
        @(posedge clk); #1;
        chk({tag, "_hold"}, 27'h0, exp_cnt);
        clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0; run = 1'b1; mem_rdy = 1'b1; ir = 32'h0; exp_cnt = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", 27'h0, 16'h0000);
        clr = 1'b1;

        push_instr(5'h00, 0); drain("add", 5'h00, 1'b1, -1);
        push_instr(5'h01, 3); drain("sub_wait3", 5'h01, 1'b1, -1);
        push_instr(5'h09, 0); drain("addi", 5'h09, 1'b1, -1);
        push_instr(5'h06, 1); drain("shl", 5'h06, 1'b1, -1);
        push_instr(5'h0C, 0); drain("nop", 5'h0C, 1'b1, -1);
        push_instr(5'h08, 0); drain("rol_rundrop", 5'h08, 1'b0, -1);
        @(posedge clk); #1; chk("idle_after", 27'h0, exp_cnt);
        @(posedge clk); #1; chk("idle_stay", 27'h0, exp_cnt);

        run = 1'b1;
        push_instr(5'h0A, 0); drain("mul", 5'h0A, 1'b0, -1);
        @(posedge clk); #1; chk("after_mul", MD_EN ? 27'h0 : (HLT | ILL), exp_cnt);
        pulse_clr("clr_mul");

        run = 1'b1;
        push_instr(5'h0C, 0); drain("nop2", 5'h0C, 1'b1, -1);
        push_instr(5'h0D, 0); drain("halt", 5'h0D, 1'b1, -1);
        @(posedge clk); #1; chk("halt_stay0", HLT, exp_cnt);
        @(posedge clk); #1; chk("halt_stay1", HLT, exp_cnt);
        pulse_clr("clr_halt");

        run = 1'b1;
        push_instr(5'h02, 0); drain("and", 5'h02, 1'b1, -1);
        push_instr(5'h1F, 2); drain("ill1f", 5'h1F, 1'b1, -1);
        @(posedge clk); #1; chk("ill_stay0", HLT | ILL, exp_cnt);
        @(posedge clk); #1; chk("ill_stay1", HLT | ILL, exp_cnt);
        pulse_clr("clr_ill");
        @(posedge clk); #1; chk("idle_post_ill", 27'h0, exp_cnt);

        // Counter preload stands in for 65534 retired NOPs.
        force dut.instr_cnt = 16'hFFFE;
        @(posedge clk); #1;
        release dut.instr_cnt;
        exp_cnt = 16'hFFFE;
        @(posedge clk); #1; chk("preload", 27'h0, exp_cnt);
        run = 1'b1;
        push_instr(5'h0C, 0); drain("nop_ffff", 5'h0C, 1'b1, -1);
        push_instr(5'h0C, 0); drain("nop_wrap", 5'h0C, 1'b0, -1);
        @(posedge clk); #1; chk("wrap_idle", 27'h0, 16'h0000);

        run = 1'b1;
        push_instr(5'h00, 0); drain("add_abort", 5'h00, 1'b1, 5);
        sb.delete();
        #2;
        clr = 1'b0;
        #1;
        exp_cnt = 16'h0000;
        chk("abort_async", 27'h0, exp_cnt);
        @(posedge clk); #1; chk("abort_hold", 27'h0, exp_cnt);
        run = 1'b0;
        clr = 1'b1;
        @(posedge clk); #1; chk("abort_idle", 27'h0, exp_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide ports: clk  in  1  system clock, rising edge; clr  in  1  asynchronous, active-low reset.
REQ-002 SHALL provide: run  in  1  permit instruction execution; ir  in  32  instruction register contents, opcode = ir[31:27]; mem_rdy  in  1  memory read-data-valid.
REQ-003 SHALL provide fetch outputs, 1 bit each: PCout, MARin, IncPC, MDRread, MDRin, MDRout, IRin.
REQ-004 SHALL provide register-select outputs, 1 bit each: Gra, Grb, Grc, Rin, Rout.
REQ-005 SHALL provide execute outputs: Yin, Zlowin, Zhighin, ZLowout, ZHighout, HIin, LOin, Cout (1 bit each) and ALUselect (5 bits).
REQ-006 SHALL provide status outputs: halted  1, illegal  1, instr_cnt  16  count of retired instructions.

Function
REQ-007 SHALL use states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, held in a state register; control outputs SHALL be decoded combinationally from state and opcode.
REQ-008 SHALL go IDLE->T0 when run=1; otherwise it SHALL stay in IDLE.
REQ-009 SHALL assert in T0: PCout, MARin, IncPC; then go to T1.
REQ-010 SHALL assert MDRread and MDRin in T1 and stay in T1 until mem_rdy=1; it SHALL go to T2 on the cycle mem_rdy=1 is sampled.
REQ-011 SHALL assert in T2: MDRout, IRin; then go to T3.
REQ-012 For R-type opcodes 5'h00-5'h08 (add, sub, and, or, shr, shra, shl, ror, rol), SHALL assert:
  - T3: Grb, Rout, Yin;
  - T4: Grc, Rout, Zlowin, Zhighin, with ALUselect=opcode;
  - T5: ZLowout, Gra, Rin.
REQ-013 For ADDI (5'h09), SHALL follow REQ-012 except T4 asserts Cout instead of Grc/Rout, with ALUselect=5'h00.
REQ-014 For MUL (5'h0A) and DIV (5'h0B), SHALL assert:
  - T3: Gra, Rout, Yin;
  - T4: Grb, Rout, Zlowin, Zhighin, with ALUselect=opcode;
  - T5: ZLowout, LOin;
  - T6: ZHighout, HIin.
REQ-015 NOP (5'h0C) SHALL complete in T3 with no outputs asserted.
REQ-016 HALT (5'h0D) SHALL go T3->HALT and assert halted.
REQ-017 Any other opcode SHALL go T3->HALT and assert halted and illegal.
REQ-018 On completion of an instruction's last state, SHALL increment instr_cnt (16-bit wrap, 16'hFFFF->16'h0000) and go to T0 if run=1, else IDLE.
REQ-019 run SHALL be sampled only in IDLE and at instruction completion; deasserting run mid-instruction SHALL NOT abort it.
REQ-020 HALT SHALL be exited only by reset; HALT and illegal instructions SHALL NOT increment instr_cnt.
REQ-021 ALUselect SHALL be 5'h00 in every state not listed above.
REQ-022 Every control output not listed for a state SHALL be 0.

Reset
REQ-023 clr=0 SHALL immediately force state=IDLE, instr_cnt=0, halted=0, illegal=0, and all control outputs 0, including mid-instruction and in HALT.
REQ-024 After clr rises, T0 SHALL be entered no earlier than the first rising clk edge with run=1.

Configuration
REQ-025 Macro SEQ_MULDIV_EN defined: opcodes 5'h0A/5'h0B SHALL execute per REQ-014.
REQ-026 Macro SEQ_MULDIV_EN undefined: opcodes 5'h0A/5'h0B SHALL be treated as illegal per REQ-017, and state T6 SHALL NOT be reachable.

Verification
REQ-027 Reset with run=1, mem_rdy=1, ir=32'h0000_0000 (add) -> T0..T5 in 6 cycles; ALUselect=5'h00 in T4; instr_cnt=1 at the T0 re-entry.
REQ-028 mem_rdy held 0 for 3 cycles in T1 -> MDRread/MDRin held for 4 cycles total; IRin asserted exactly once, in the cycle after mem_rdy=1.
REQ-029 ir opcode 5'h0A with SEQ_MULDIV_EN -> LOin in T5, HIin in T6, 7 cycles total; same stimulus without the macro -> halted=1, illegal=1 after T3.
REQ-030 ir opcode 5'h1F -> HALT with illegal=1, instr_cnt unchanged; then clr pulsed low -> IDLE, all outputs 0.
REQ-031 instr_cnt preloaded by running 65535 NOPs, then one more NOP -> instr_cnt=16'h0000; clr asserted during T4 of an add -> outputs 0 asynchronously, Rin never asserted.
